// File: rtl/pci_hpram_arbiter.sv
// rtl/pci_hpram_arbiter.sv - HPRAM sharing between the PCI target FSM and one local requester
// PCI passes through combinationally while it owns the RAM; local accesses use a req/ack handshake.
module pci_hpram_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int CNT_W        = 8,
    parameter int STARVE_LIMIT = 200
) (
    input  logic              PHY_CLK33_I,
    input  logic              PHY_RST_I,
    input  logic              PCI_CLAIM_I,
    input  logic              PCI_IDLE_I,
    input  logic [ADDR_W-1:0] PCI_RAM_ADD_I,
    input  logic [31:0]       PCI_RAM_DATA_I,
    input  logic [3:0]        PCI_RAM_WEN_I,
    input  logic              LOC_REQ_I,
    input  logic              LOC_WR_I,
    input  logic [ADDR_W-1:0] LOC_ADD_I,
    input  logic [31:0]       LOC_DATA_I,
    input  logic [3:0]        LOC_BE_I,
    output logic              LOC_ACK_O,
    output logic [31:0]       LOC_RDATA_O,
    output logic              LOC_STARVE_O,
    output logic              PCI_OWN_O,
    output logic [ADDR_W-1:0] RAM_ADD_O,
    output logic [31:0]       RAM_DATA_O,
    output logic [3:0]        RAM_WEN_O,
    input  logic [31:0]       RAM_DATA_I
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

    state_t            state;
    logic [ADDR_W-1:0] loc_add_q;
    logic [31:0]       loc_data_q;
    logic [3:0]        loc_be_q;
    logic              loc_wr_q;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              accept;
    logic              pending;

    // The ack cycle blocks acceptance so back-to-back local accesses are spaced by four cycles.
    assign accept   = (state == S_IDLE) && LOC_REQ_I && !PCI_CLAIM_I && !PCI_OWN_O && !LOC_ACK_O;
    assign pending  = (state == S_IDLE) && LOC_REQ_I && !accept;
    assign cnt_next = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;

    always_ff @(posedge PHY_CLK33_I) begin
        if (PHY_RST_I) begin
            state        <= S_IDLE;
            PCI_OWN_O    <= 1'b0;
            LOC_ACK_O    <= 1'b0;
            LOC_STARVE_O <= 1'b0;
            LOC_RDATA_O  <= '0;
            loc_add_q    <= '0;
            loc_data_q   <= '0;
            loc_be_q     <= '0;
            loc_wr_q     <= 1'b0;
            starve_cnt   <= '0;
        end else begin
            if (PCI_CLAIM_I) begin
                PCI_OWN_O <= 1'b1;
            end else if (PCI_OWN_O && PCI_IDLE_I) begin
                PCI_OWN_O <= 1'b0;
            end

            LOC_ACK_O <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        loc_add_q  <= LOC_ADD_I;
                        loc_data_q <= LOC_DATA_I;
                        loc_be_q   <= LOC_BE_I;
                        loc_wr_q   <= LOC_WR_I;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (!loc_wr_q) begin
                        LOC_RDATA_O <= RAM_DATA_I;
                    end
                    LOC_ACK_O <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (LOC_ACK_O) begin
                starve_cnt   <= '0;
                LOC_STARVE_O <= 1'b0;
            end else if (pending) begin
                starve_cnt <= cnt_next;
                if (cnt_next >= LIMIT) begin
                    LOC_STARVE_O <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        RAM_ADD_O  = loc_add_q;
        RAM_DATA_O = loc_data_q;
        RAM_WEN_O  = '0;
        if (PCI_OWN_O) begin
            RAM_ADD_O  = PCI_RAM_ADD_I;
            RAM_DATA_O = PCI_RAM_DATA_I;
            RAM_WEN_O  = PCI_RAM_WEN_I;
        end else if (state == S_ISSUE && loc_wr_q) begin
            RAM_WEN_O = loc_be_q;
        end
    end

endmodule

// File: tb/tb_pci_hpram_arbiter.sv
// tb/tb_pci_hpram_arbiter.sv - randomized bench with transaction-level reference model for pci_hpram_arbiter
// Directed scenarios pin the model with literal values, then random PCI/local traffic runs against it.
`timescale 1ns/1ps
module tb_pci_hpram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        claim = 1'b0;
    logic        idle_i = 1'b1;
    logic [11:0] pci_add = '0;
    logic [31:0] pci_dat = '0;
    logic [3:0]  pci_wen = '0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [11:0] ladd = '0;
    logic [31:0] ldat = '0;
    logic [3:0]  lbe = '0;
    logic        ack, starve, own;
    logic [31:0] rdata, ram_dat, ram_q;
    logic [11:0] ram_add;
    logic [3:0]  ram_wen;

    logic [31:0] ram [4096];
    logic        init_phase = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [31:0] shadow [4096];
    logic        m_own, m_ack, m_starve, m_lwr;
    int          m_age, m_cnt;
    logic [31:0] m_rdata, m_ldata, m_slot;
    logic [11:0] m_laddr;
    logic [3:0]  m_lbe;
    int          pci_left = 0;

    always #5 clk = ~clk;

    pci_hpram_arbiter dut (
        .PHY_CLK33_I   (clk),
        .PHY_RST_I     (rst),
        .PCI_CLAIM_I   (claim),
        .PCI_IDLE_I    (idle_i),
        .PCI_RAM_ADD_I (pci_add),
        .PCI_RAM_DATA_I(pci_dat),
        .PCI_RAM_WEN_I (pci_wen),
        .LOC_REQ_I     (req),
        .LOC_WR_I      (wr),
        .LOC_ADD_I     (ladd),
        .LOC_DATA_I    (ldat),
        .LOC_BE_I      (lbe),
        .LOC_ACK_O     (ack),
        .LOC_RDATA_O   (rdata),
        .LOC_STARVE_O  (starve),
        .PCI_OWN_O     (own),
        .RAM_ADD_O     (ram_add),
        .RAM_DATA_O    (ram_dat),
        .RAM_WEN_O     (ram_wen),
        .RAM_DATA_I    (ram_q)
    );

    function automatic logic [31:0] init_word(int i);
        if (i == 12'h3FF) return 32'hDEAD_BEEF;
        if (i == 12'h012) return 32'h1122_3344;
        return 32'(i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // HPRAM: synchronous read-first, byte-enabled writes
    always @(posedge clk) begin
        if (init_phase) begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_word(i);
        end else begin
            ram_q <= ram[ram_add];
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) ram[ram_add][8*b +: 8] <= ram_dat[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_ack = 0; m_starve = 0; m_lwr = 0;
        m_age = -1; m_cnt = 0;
        m_rdata = '0; m_ldata = '0; m_laddr = '0; m_lbe = '0;
    endtask

    // Compare this cycle's outputs against the model, then advance the model across the clock edge.
    task automatic step();
        logic [11:0] e_add;
        logic [31:0] e_dat;
        logic [3:0]  e_wen;
        logic        acc;
        #1;
        e_add = m_own ? pci_add : m_laddr;
        e_dat = m_own ? pci_dat : m_ldata;
        e_wen = m_own ? pci_wen : ((m_age == 1 && m_lwr) ? m_lbe : 4'h0);
        chk("own", own, m_own);
        chk("ack", ack, m_ack);
        chk("rdata", rdata, m_rdata);
        chk("starve", starve, m_starve);
        chk("ram_add", ram_add, e_add);
        chk("ram_dat", ram_dat, e_dat);
        chk("ram_wen", ram_wen, e_wen);

        if (m_age == 1) m_slot = shadow[m_laddr];
        for (int b = 0; b < 4; b++)
            if (e_wen[b]) shadow[e_add][8*b +: 8] = e_dat[8*b +: 8];

        if (rst) begin
            model_reset();
        end else begin
            acc = (m_age < 0) && req && !claim && !m_own && !m_ack;
            if (m_ack) begin
                m_cnt = 0; m_starve = 0;
            end else if (req && m_age < 0 && !acc) begin
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                if (m_cnt >= 200) m_starve = 1;
            end
            m_ack = (m_age == 2);
            if (m_age == 2 && !m_lwr) m_rdata = m_slot;
            if (claim) m_own = 1;
            else if (m_own && idle_i) m_own = 0;
            if (m_age == 2) m_age = -1;
            else if (m_age == 1) m_age = 2;
            else if (acc) begin
                m_age = 1; m_laddr = ladd; m_ldata = ldat; m_lbe = lbe; m_lwr = wr;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_loc(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        req = 1; wr = w; ladd = a; ldat = d; lbe = be;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) shadow[i] = init_word(i);
        model_reset();
        m_slot = '0;
        repeat (3) @(negedge clk);
        init_phase = 0;
        rst = 0;

        chk("reset_ack", ack, 0);
        chk("reset_own", own, 0);
        chk("reset_starve", starve, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_ram_add", ram_add, 0);
        chk("reset_ram_wen", ram_wen, 0);

        // local write, PCI idle
        set_loc(1, 12'h012, 32'hA5A5_5A5F, 4'b0101);
        step();
        chk("wr_slot_wen", ram_wen, 4'b0101);
        chk("wr_slot_add", ram_add, 12'h012);
        step();
        chk("wr_after_wen", ram_wen, 4'b0000);
        step();
        chk("wr_ack", ack, 1);
        req = 0;
        step();
        chk("wr_ack_pulse", ack, 0);

        // read back merged word, then read preloaded word
        set_loc(0, 12'h012, 32'h0, 4'h0);
        step(); step(); step();
        chk("rd012_ack", ack, 1);
        chk("rd012_data", rdata, 32'h11A5_335F);
        req = 0;
        step();
        set_loc(0, 12'h3FF, 32'h0, 4'h0);
        step(); step(); step();
        chk("rd3ff_ack", ack, 1);
        chk("rd3ff_data", rdata, 32'hDEAD_BEEF);
        req = 0;
        step(); step();
        chk("rd3ff_held", rdata, 32'hDEAD_BEEF);

        // claim and request in the same cycle
        claim = 1; idle_i = 1; pci_add = 12'h0AB; pci_wen = 0;
        set_loc(0, 12'h005, 32'h0, 4'h0);
        step();
        chk("cvr_own", own, 1);
        chk("cvr_pass_add", ram_add, 12'h0AB);
        claim = 0; idle_i = 0;
        repeat (3) step();
        idle_i = 1;
        step();
        step(); step(); step();
        chk("cvr_ack", ack, 1);
        req = 0;
        step();

        // claim while the local access is in its RAM slot
        set_loc(0, 12'h3FF, 32'h0, 4'h0);
        step();
        claim = 1;
        step();
        claim = 0; idle_i = 0; pci_add = 12'h3FF; pci_dat = 32'hCAFE_F00D; pci_wen = 4'hF;
        #1;
        chk("cdi_pass_wen", ram_wen, 4'hF);
        step();
        chk("cdi_ack", ack, 1);
        chk("cdi_data", rdata, 32'hDEAD_BEEF);
        req = 0; idle_i = 1; pci_wen = 0;
        step();
        set_loc(0, 12'h3FF, 32'h0, 4'h0);
        step(); step(); step();
        chk("cdi_pci_wrote", rdata, 32'hCAFE_F00D);
        req = 0;
        step();

        // starvation under a long PCI transaction
        claim = 1; idle_i = 1;
        set_loc(1, 12'h020, 32'h0123_4567, 4'hF);
        step();
        claim = 0; idle_i = 0;
        repeat (198) step();
        chk("starve_199", starve, 0);
        step();
        chk("starve_200", starve, 1);
        repeat (50) step();
        idle_i = 1;
        step();
        step(); step(); step();
        chk("starve_ack", ack, 1);
        chk("starve_at_ack", starve, 1);
        req = 0;
        step();
        chk("starve_cleared", starve, 0);

        // reset in CAPTURE
        set_loc(0, 12'h005, 32'h0, 4'h0);
        step(); step();
        rst = 1;
        step();
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_own", own, 0);
        chk("rst_ram_add", ram_add, 0);
        rst = 0; req = 0;
        step();

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            if (pci_left > 0) begin
                idle_i = 0; claim = 0; pci_left--;
                pci_wen = 4'($urandom_range(0, 15));
            end else begin
                idle_i = 1; pci_wen = 0;
                claim = ($urandom_range(0, 5) == 0);
                if (claim) pci_left = $urandom_range(1, 5);
            end
            pci_add = 12'($urandom_range(0, 15));
            pci_dat = $urandom;
            if (req) begin
                if (m_ack) req = 0;
                else if (m_age < 0 && $urandom_range(0, 29) == 0) req = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                set_loc(1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom,
                        4'($urandom_range(0, 15)));
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pci_hpram_arbiter.md
Name: pci_hpram_arbiter

Overview:
- Shares the single-port HPRAM (12-bit word address, 32-bit data, 4 byte-write-enables, 1-cycle synchronous read) between the PCI target memory FSM and one local-logic requester.
- PCI has absolute priority and is never stalled: its RAM signals pass through combinationally while it owns the RAM.
- The local side uses a req/ack handshake for single-word accesses.
- The block sits between the PCI target memory FSM, the local user logic and the HPRAM primitive.

Parameters:
- ADDR_W, 12, RAM word-address width.
- CNT_W, 8, starvation counter width.
- STARVE_LIMIT, 200, count of pending-request cycles at which LOC_STARVE_O is raised; must be less than 2^CNT_W.

Ports:
- PHY_CLK33_I  in  1  PCI 33 MHz clock; the only clock.
- PHY_RST_I  in  1  synchronous, active-high reset.
- PCI_CLAIM_I  in  1  one-cycle pulse: the PCI FSM has decoded a hit and drives the RAM from the next cycle.
- PCI_IDLE_I  in  1  high while the PCI FSM is in its ready state.
- PCI_RAM_ADD_I  in  ADDR_W  PCI-side RAM address.
- PCI_RAM_DATA_I  in  32  PCI-side RAM write data.
- PCI_RAM_WEN_I  in  4  PCI-side byte write enables, active high.
- LOC_REQ_I  in  1  local access request, level; held with its qualifiers until LOC_ACK_O.
- LOC_WR_I  in  1  local access type: 1 = write, 0 = read.
- LOC_ADD_I  in  ADDR_W  local word address.
- LOC_DATA_I  in  32  local write data.
- LOC_BE_I  in  4  local byte enables, active high.
- LOC_ACK_O  out  1  one-cycle completion pulse.
- LOC_RDATA_O  out  32  local read data; valid with LOC_ACK_O and held until the next ack.
- LOC_STARVE_O  out  1  sticky flag: the local request has been pending STARVE_LIMIT cycles.
- PCI_OWN_O  out  1  PCI currently owns the RAM.
- RAM_ADD_O  out  ADDR_W  to HPRAM.
- RAM_DATA_O  out  32  to HPRAM.
- RAM_WEN_O  out  4  to HPRAM.
- RAM_DATA_I  in  32  from HPRAM.

Behaviour:
- Reset values (synchronous, takes priority over everything):
  - state=IDLE, PCI_OWN_O=0, LOC_ACK_O=0, LOC_STARVE_O=0.
  - LOC_RDATA_O=0, latched local address/data/be/wr=0, starvation counter=0.
  - Resulting RAM outputs: RAM_WEN_O=0, RAM_ADD_O=0, RAM_DATA_O=0.
  - Reset during a local access drops it with no ack; the requester re-requests.
- Ownership flag PCI_OWN_O (registered):
  - Set at the clock edge where PCI_CLAIM_I=1.
  - Cleared at the edge where PCI_OWN_O=1, PCI_IDLE_I=1 and PCI_CLAIM_I=0.
  - A claim in the same cycle as PCI_IDLE_I=1 keeps ownership, so back-to-back PCI transactions have no gap.
- RAM mux (combinational):
  - PCI_OWN_O=1: RAM_ADD_O, RAM_DATA_O and RAM_WEN_O equal the PCI inputs.
  - Otherwise: RAM_ADD_O and RAM_DATA_O are the latched local values. RAM_WEN_O = latched BE if state=ISSUE and the access is a write, else 0.
- Local FSM:
  - IDLE → ISSUE when LOC_REQ_I=1, PCI_CLAIM_I=0, PCI_OWN_O=0 and LOC_ACK_O=0. On that edge, latch LOC_ADD_I, LOC_DATA_I, LOC_BE_I and LOC_WR_I.
  - ISSUE: the RAM slot cycle. Unconditionally → CAPTURE.
  - CAPTURE: LOC_RDATA_O <= RAM_DATA_I if read (unchanged on write); LOC_ACK_O <= 1; → IDLE.
  - LOC_ACK_O is cleared the following cycle.
- Latency: from the accept cycle T, the RAM slot is T+1 and LOC_ACK_O is high in T+3. The earliest next accept is T+4, because the ack cycle blocks acceptance.
- Claim vs local access:
  - A claim arriving while the FSM is in ISSUE takes the RAM from the next cycle. The local slot has already completed, and its read data is captured normally in CAPTURE.
  - A local access is never aborted.
  - A claim in IDLE blocks acceptance in that same cycle.
- Starvation:
  - The counter increments each cycle LOC_REQ_I=1 and the FSM is in IDLE without accepting. It saturates at 2^CNT_W-1.
  - LOC_STARVE_O is set when count ≥ STARVE_LIMIT.
  - Both the counter and LOC_STARVE_O clear on LOC_ACK_O.
- LOC_REQ_I dropped before accept: no access takes place and the counter holds its value.

Test Plan:
- Local write, PCI idle. LOC_REQ_I=1, WR=1, ADD=0x012, DATA=0xA5A5_5A5F, BE=4'b0101 at T → RAM_WEN_O=4'b0101 with ADD 0x012 only in T+1; LOC_ACK_O pulses at T+3. A subsequent local read of 0x012 returns bytes 0 and 2 updated.
- Local read. Preload word 0x3FF=0xDEAD_BEEF; request read at T → LOC_RDATA_O=0xDEAD_BEEF with ACK at T+3, held afterwards.
- Claim vs request. PCI_CLAIM_I and LOC_REQ_I both high at T → PCI_OWN_O=1 from T+1 and the PCI address passes through. Local is accepted only after PCI_IDLE_I returns, then acked 3 cycles later.
- Claim during ISSUE. Accept at T, claim at T+1 → local slot at T+1 completes with correct read data and ack at T+3; PCI writes from T+2 reach RAM unmodified.
- Starvation. STARVE_LIMIT=200; hold PCI busy for 250 cycles with LOC_REQ_I=1 → LOC_STARVE_O rises on the 200th pending cycle and clears with the eventual ack.
- Reset mid-op. Assert PHY_RST_I in CAPTURE → no ack, and all outputs at reset values the next cycle.
